// File: rtl/updn_counter_bcd.sv
// rtl/updn_counter_bcd.sv - N-digit BCD up/down counter with debounced push buttons and 7-segment scan
//
// Purpose:
//   Two active-low buttons (up/down) are synchronised, debounced and edge
//   detected. Each accepted press steps a DIGITS-wide BCD counter up or down.
//   At the count limits, i_Mode selects wrap or saturate behaviour. The count
//   is shown on a time-multiplexed, active-low 7-segment display and mirrored
//   (least significant digit) on four LEDs.
//
// Configuration:
//   AUTO_REPEAT_EN - when defined, holding exactly one button issues extra
//                    steps after RPT_DELAY clocks and then every RPT_PERIOD
//                    clocks. When undefined, one step per press only.
//
// Ports:
//   i_Clk    system clock
//   i_Rst    asynchronous reset, active-high
//   i_Push   buttons, active-low; [1]=up, [0]=down
//   i_Mode   0=wrap, 1=saturate at the limits
//   o_Cnt    BCD count, digit k at [4k+3:4k]
//   o_Carry  one-clock pulse when the count wraps in either direction
//   o_LED    copy of o_Cnt[3:0]
//   o_Digit  one-hot digit enable, active-high
//   o_FND    segments of the enabled digit, active-low, bit0=a .. bit6=g

module updn_counter_bcd #(
    parameter int DIGITS     = 4,
    parameter int DB_CYCLES  = 500000,
    parameter int SCAN_DIV   = 50000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [1:0]            i_Push,
    input  logic                  i_Mode,
    output logic [4*DIGITS-1:0]   o_Cnt,
    output logic                  o_Carry,
    output logic [3:0]            o_LED,
    output logic [DIGITS-1:0]     o_Digit,
    output logic [6:0]            o_FND
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // ------------------------------------------------------------------
    // Button path: synchroniser, debounce, press detect
    // ------------------------------------------------------------------
    logic [1:0]      r_sync1;
    logic [1:0]      r_sync2;
    logic [1:0]      r_sync_vld;
    logic [1:0]      r_db;
    logic [1:0]      r_db_d;
    logic [1:0]      r_armed;
    logic [DB_W-1:0] r_db_cnt [2];

    logic [1:0]      w_press;
    logic [1:0]      w_held;
    logic            w_hold_one;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_sync1     <= 2'b11;
            r_sync2     <= 2'b11;
            r_sync_vld  <= 2'b00;
            r_db        <= 2'b11;
            r_db_d      <= 2'b11;
            r_armed     <= 2'b00;
            r_db_cnt[0] <= '0;
            r_db_cnt[1] <= '0;
        end else begin
            r_sync1    <= i_Push;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            r_db_d     <= r_db;
            for (int k = 0; k < 2; k++) begin
                if (r_sync2[k] == r_db[k]) begin
                    r_db_cnt[k] <= '0;
                end else if (r_db_cnt[k] == DB_W'(DB_CYCLES)) begin
                    r_db[k]     <= r_sync2[k];
                    r_db_cnt[k] <= '0;
                end else begin
                    r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                end
                // The synchroniser resets to "released", so a button held
                // through reset would otherwise look like a fresh press once
                // its low level is debounced. A channel only becomes live after
                // it has really been seen released (valid synchroniser output
                // agreeing with a released debounced level).
                if (r_sync_vld[1] && r_sync2[k] && r_db[k])
                    r_armed[k] <= 1'b1;
            end
        end
    end

    assign w_press    = r_armed & r_db_d & ~r_db;
    assign w_held     = r_armed & ~r_db;
    assign w_hold_one = (w_held == 2'b01) || (w_held == 2'b10);

    // ------------------------------------------------------------------
    // Auto-repeat hold timer
    // ------------------------------------------------------------------
    logic [1:0] w_rpt;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    logic [RPT_W-1:0] r_rpt_cnt;
    logic             r_rpt_first;
    logic [RPT_W-1:0] w_rpt_tgt;
    logic             w_rpt_fire;

    // The timer is 0 on the press cycle and 1 right after it, so matching
    // RPT_DELAY places the first extra step exactly RPT_DELAY clocks after
    // the press step; reloading to 1 gives RPT_PERIOD spacing afterwards.
    assign w_rpt_tgt  = r_rpt_first ? RPT_W'(RPT_DELAY) : RPT_W'(RPT_PERIOD);
    assign w_rpt_fire = w_hold_one && (r_rpt_cnt == w_rpt_tgt);
    assign w_rpt      = w_rpt_fire ? w_held : 2'b00;

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (!w_hold_one) begin
            r_rpt_cnt   <= '0;
            r_rpt_first <= 1'b1;
        end else if (w_rpt_fire) begin
            r_rpt_cnt   <= RPT_W'(1);
            r_rpt_first <= 1'b0;
        end else begin
            r_rpt_cnt   <= r_rpt_cnt + 1'b1;
        end
    end
`else
    // Repeat parameters have no effect in this build; the sanity term only
    // keeps them referenced.
    localparam bit RPT_CFG_OK = (RPT_DELAY >= 1) && (RPT_PERIOD >= 1);
    assign w_rpt = {2{1'b0 & RPT_CFG_OK}};
    logic w_unused_hold;
    assign w_unused_hold = w_hold_one;
`endif

    // ------------------------------------------------------------------
    // BCD counter
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_cnt;
    logic                r_carry;
    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_dec;
    logic                w_at_max;
    logic                w_at_zero;
    logic                w_up;
    logic                w_dn;

    assign w_up = w_press[1] | w_rpt[1];
    assign w_dn = w_press[0] | w_rpt[0];

    // Ripple +1 / -1 through the digits; a carry (borrow) out of the top
    // digit means the count was all nines (all zeros).
    always_comb begin : p_bcd
        logic v_c;
        logic v_b;
        w_inc = r_cnt;
        w_dec = r_cnt;
        v_c   = 1'b1;
        v_b   = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (v_c) begin
                if (r_cnt[4*k +: 4] == 4'd9) begin
                    w_inc[4*k +: 4] = 4'd0;
                end else begin
                    w_inc[4*k +: 4] = r_cnt[4*k +: 4] + 4'd1;
                    v_c = 1'b0;
                end
            end
            if (v_b) begin
                if (r_cnt[4*k +: 4] == 4'd0) begin
                    w_dec[4*k +: 4] = 4'd9;
                end else begin
                    w_dec[4*k +: 4] = r_cnt[4*k +: 4] - 4'd1;
                    v_b = 1'b0;
                end
            end
        end
        w_at_max  = v_c;
        w_at_zero = v_b;
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_cnt   <= '0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (w_up && !w_dn) begin
                if (!w_at_max) begin
                    r_cnt <= w_inc;
                end else if (!i_Mode) begin
                    r_cnt   <= w_inc;
                    r_carry <= 1'b1;
                end
            end else if (w_dn && !w_up) begin
                if (!w_at_zero) begin
                    r_cnt <= w_dec;
                end else if (!i_Mode) begin
                    r_cnt   <= w_dec;
                    r_carry <= 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan
    // ------------------------------------------------------------------
    function automatic logic [6:0] f_seg(input logic [3:0] v);
        case (v)
            4'd0:    f_seg = 7'b1000000;
            4'd1:    f_seg = 7'b1111001;
            4'd2:    f_seg = 7'b0100100;
            4'd3:    f_seg = 7'b0110000;
            4'd4:    f_seg = 7'b0011001;
            4'd5:    f_seg = 7'b0010010;
            4'd6:    f_seg = 7'b0000010;
            4'd7:    f_seg = 7'b1111000;
            4'd8:    f_seg = 7'b0000000;
            4'd9:    f_seg = 7'b0010000;
            default: f_seg = 7'h7F;
        endcase
    endfunction

    logic [SCAN_W-1:0] r_scan_cnt;
    logic [DIG_W-1:0]  r_dig_idx;
    logic [DIGITS-1:0] r_digit;
    logic [6:0]        r_fnd;
    logic              w_scan_tick;
    logic [DIG_W-1:0]  w_nxt_idx;
    logic [DIGITS-1:0] w_digit_nxt;
    logic [3:0]        w_nxt_val;

    assign w_scan_tick = (r_scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign w_nxt_idx   = (r_dig_idx == DIG_W'(DIGITS - 1)) ? '0 : r_dig_idx + 1'b1;

    always_comb begin
        w_digit_nxt = '0;
        w_nxt_val   = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (DIG_W'(k) == w_nxt_idx) begin
                w_digit_nxt[k] = 1'b1;
                w_nxt_val      = r_cnt[4*k +: 4];
            end
        end
    end

    // Segments are decoded for the digit about to be enabled so that o_FND
    // and o_Digit change together on the scan tick.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= '0;
            r_digit    <= DIGITS'(1);
            r_fnd      <= 7'b1000000;
        end else if (w_scan_tick) begin
            r_scan_cnt <= '0;
            r_dig_idx  <= w_nxt_idx;
            r_digit    <= w_digit_nxt;
            r_fnd      <= f_seg(w_nxt_val);
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    assign o_Cnt   = r_cnt;
    assign o_Carry = r_carry;
    assign o_LED   = r_cnt[3:0];
    assign o_Digit = r_digit;
    assign o_FND   = r_fnd;

endmodule

// File: tb/tb_updn_counter_bcd.sv
// tb/tb_updn_counter_bcd.sv - directed self-checking bench for updn_counter_bcd (DIGITS=2)

module tb_updn_counter_bcd;

    logic       i_Clk = 1'b0;
    logic       i_Rst = 1'b1;
    logic [1:0] i_Push = 2'b11;
    logic       i_Mode = 1'b0;
    logic [7:0] o_Cnt;
    logic       o_Carry;
    logic [3:0] o_LED;
    logic [1:0] o_Digit;
    logic [6:0] o_FND;

    int n_checks = 0;
    int n_fail   = 0;

    updn_counter_bcd #(
        .DIGITS     (2),
        .DB_CYCLES  (4),
        .SCAN_DIV   (4),
        .RPT_DELAY  (20),
        .RPT_PERIOD (8)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst   (i_Rst),
        .i_Push  (i_Push),
        .i_Mode  (i_Mode),
        .o_Cnt   (o_Cnt),
        .o_Carry (o_Carry),
        .o_LED   (o_LED),
        .o_Digit (o_Digit),
        .o_FND   (o_FND)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic tick();
        @(posedge i_Clk);
        @(negedge i_Clk);
    endtask

    // up=1 -> i_Push=2'b01 (up pressed), up=0 -> 2'b10 (down pressed)
    task automatic do_press(input bit up, input int hold, input int rel, output int carries);
        carries = 0;
        i_Push = up ? 2'b01 : 2'b10;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (o_Carry === 1'b1) carries++;
        end
        i_Push = 2'b11;
        for (int i = 0; i < rel; i++) begin
            tick();
            if (o_Carry === 1'b1) carries++;
        end
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        i_Push = 2'b11;
        repeat (3) @(negedge i_Clk);
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL reset_cnt: got %h want 00", o_Cnt); end
        n_checks++; if (o_Carry !== 1'b0) begin n_fail++; $display("FAIL reset_carry: got %b want 0", o_Carry); end
        n_checks++; if (o_Digit !== 2'b01) begin n_fail++; $display("FAIL reset_digit: got %b want 01", o_Digit); end
        n_checks++; if (o_FND !== 7'b1000000) begin n_fail++; $display("FAIL reset_fnd: got %b want 1000000", o_FND); end
        n_checks++; if (o_LED !== 4'h0) begin n_fail++; $display("FAIL reset_led: got %h want 0", o_LED); end
        i_Rst = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_first_press();
        int c;
        i_Push = 2'b01;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (k == 6) begin
                n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL latency_edge6: got %h want 00", o_Cnt); end
            end
            if (k == 7) begin
                n_checks++; if (o_Cnt !== 8'h01) begin n_fail++; $display("FAIL latency_edge7: got %h want 01", o_Cnt); end
                n_checks++; if (o_LED !== 4'h1) begin n_fail++; $display("FAIL led_mirror: got %h want 1", o_LED); end
            end
        end
        i_Push = 2'b11;
        repeat (10) tick();
        for (int n = 0; n < 9; n++) do_press(1'b1, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h10) begin n_fail++; $display("FAIL bcd_carry_10: got %h want 10", o_Cnt); end
    endtask

    task automatic test_glitch();
        i_Push = 2'b01;
        repeat (3) tick();
        i_Push = 2'b11;
        repeat (10) tick();
        n_checks++; if (o_Cnt !== 8'h10) begin n_fail++; $display("FAIL glitch_up: got %h want 10", o_Cnt); end
        i_Push = 2'b10;
        repeat (3) tick();
        i_Push = 2'b11;
        repeat (10) tick();
        n_checks++; if (o_Cnt !== 8'h10) begin n_fail++; $display("FAIL glitch_dn: got %h want 10", o_Cnt); end
    endtask

    task automatic test_both();
        int c = 0;
        i_Push = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (o_Carry === 1'b1) c++;
        end
        i_Push = 2'b11;
        repeat (10) tick();
        n_checks++; if (o_Cnt !== 8'h10) begin n_fail++; $display("FAIL both_cnt: got %h want 10", o_Cnt); end
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL both_carry: got %0d pulses want 0", c); end
    endtask

    task automatic test_borrow_and_wrap();
        int c;
        do_press(1'b0, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h09) begin n_fail++; $display("FAIL borrow_09: got %h want 09", o_Cnt); end
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL borrow_carry: got %0d want 0", c); end
        for (int n = 0; n < 9; n++) do_press(1'b0, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL down_to_00: got %h want 00", o_Cnt); end
        do_press(1'b0, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h99) begin n_fail++; $display("FAIL wrap_down_cnt: got %h want 99", o_Cnt); end
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL wrap_down_carry: got %0d pulses want 1", c); end
        do_press(1'b1, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL wrap_up_cnt: got %h want 00", o_Cnt); end
        n_checks++; if (c !== 1) begin n_fail++; $display("FAIL wrap_up_carry: got %0d pulses want 1", c); end
    endtask

    task automatic test_saturate();
        int c;
        i_Mode = 1'b1;
        repeat (3) tick();
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL mode_change_cnt: got %h want 00", o_Cnt); end
        do_press(1'b0, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL sat_low_cnt: got %h want 00", o_Cnt); end
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL sat_low_carry: got %0d want 0", c); end
        i_Mode = 1'b0;
        do_press(1'b0, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h99) begin n_fail++; $display("FAIL rewrap_cnt: got %h want 99", o_Cnt); end
        i_Mode = 1'b1;
        do_press(1'b1, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h99) begin n_fail++; $display("FAIL sat_high_cnt: got %h want 99", o_Cnt); end
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL sat_high_carry: got %0d want 0", c); end
        i_Mode = 1'b0;
    endtask

    task automatic test_scan();
        int   c;
        bit   found;
        logic [1:0] first;
        logic [1:0] prev;
        logic [1:0] exp_dig;
        logic [6:0] exp_fnd;
        do_press(1'b1, 10, 10, c);
        for (int n = 0; n < 42; n++) do_press(1'b1, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h42) begin n_fail++; $display("FAIL reach_42: got %h want 42", o_Cnt); end
        prev = o_Digit;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (o_Digit !== prev) found = 1'b1;
        end
        n_checks++; if (!found) begin n_fail++; $display("FAIL scan_timeout: o_Digit stuck at %b", o_Digit); end
        first = (prev == 2'b01) ? 2'b10 : 2'b01;
        for (int i = 0; i < 16; i++) begin
            exp_dig = (((i / 4) % 2) == 0) ? first : ~first;
            exp_fnd = (exp_dig == 2'b01) ? 7'b0100100 : 7'b0011001;
            n_checks++; if (o_Digit !== exp_dig) begin n_fail++; $display("FAIL scan_digit[%0d]: got %b want %b", i, o_Digit, exp_dig); end
            n_checks++; if (o_FND !== exp_fnd) begin n_fail++; $display("FAIL scan_fnd[%0d]: got %b want %b", i, o_FND, exp_fnd); end
            tick();
        end
    endtask

    task automatic test_reset_hold();
        int c = 0;
        i_Push = 2'b01;
        repeat (8) tick();
        n_checks++; if (o_Cnt !== 8'h43) begin n_fail++; $display("FAIL pre_reset_cnt: got %h want 43", o_Cnt); end
        i_Rst = 1'b1;
        #1;
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL async_reset_cnt: got %h want 00", o_Cnt); end
        repeat (2) tick();
        i_Rst = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (o_Carry === 1'b1) c++;
        end
        n_checks++; if (o_Cnt !== 8'h00) begin n_fail++; $display("FAIL held_after_reset: got %h want 00", o_Cnt); end
        n_checks++; if (c !== 0) begin n_fail++; $display("FAIL held_after_reset_carry: got %0d want 0", c); end
        i_Push = 2'b11;
        repeat (10) tick();
        do_press(1'b1, 10, 10, c);
        n_checks++; if (o_Cnt !== 8'h01) begin n_fail++; $display("FAIL repress_after_reset: got %h want 01", o_Cnt); end
    endtask

    task automatic test_long_hold();
        int c;
        logic [7:0] exp_cnt;
`ifdef AUTO_REPEAT_EN
        exp_cnt = 8'h06;
`else
        exp_cnt = 8'h01;
`endif
        i_Rst = 1'b1;
        repeat (2) tick();
        i_Rst = 1'b0;
        repeat (6) tick();
        do_press(1'b1, 60, 12, c);
        n_checks++; if (o_Cnt !== exp_cnt) begin n_fail++; $display("FAIL long_hold: got %h want %h", o_Cnt, exp_cnt); end
    endtask

    initial begin
        test_reset();
        test_first_press();
        test_glitch();
        test_both();
        test_borrow_and_wrap();
        test_saturate();
        test_scan();
        test_reset_hold();
        test_long_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/updn_counter_bcd.md
Name: updn_counter_bcd

Overview:
- Parametrised N-digit BCD up/down counter driven by two active-low push buttons.
- Button path per channel: 2-flop synchroniser, debounce, press (falling-edge) detect.
- Mode input selects wrap or saturate at the count limits.
- Drives a time-multiplexed active-low 7-segment display and a 4-bit LED mirror of the least significant digit. Sits directly under the board top-level, replacing the single-digit button counter.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); count range 0 .. 10^DIGITS-1
- DB_CYCLES, 500000, consecutive stable clocks required to accept a button level (10 ms at 50 MHz); minimum 1
- SCAN_DIV, 50000, clocks each digit stays enabled during display scan; minimum 1
- RPT_DELAY, 25000000, hold clocks before auto-repeat starts (only with macro)
- RPT_PERIOD, 5000000, clocks between auto-repeat steps (only with macro)

Ports:
- i_Clk  in  1  system clock, 50 MHz
- i_Rst  in  1  asynchronous reset, active-high
- i_Push  in  2  buttons, active-low; [1]=up, [0]=down
- i_Mode  in  1  0=wrap, 1=saturate
- o_Cnt  out  4*DIGITS  BCD count; digit k at [4k+3:4k]
- o_Carry  out  1  one-clock pulse on wrap (either direction)
- o_LED  out  4  equals o_Cnt[3:0]
- o_Digit  out  DIGITS  one-hot digit enable, active-high
- o_FND  out  7  segments of enabled digit, active-low; bit0=a .. bit6=g

Behaviour:
- Reset (async, active-high):
  - o_Cnt=0, o_Carry=0, o_Digit=1 (digit 0 enabled), o_FND=7'b1000000 ("0").
  - Synchroniser flops and debounced levels = 1 (released); all timers = 0.
- Debounce, per button:
  - Stability counter clears whenever the synchronised level equals the debounced level.
  - Otherwise it increments; when it reaches DB_CYCLES, the debounced level takes the synchronised value and the counter clears.
- Press: debounced level 1->0, one-clock pulse. Release produces nothing.
- Latency:
  - Raw falling edge held stable at edge 0 -> debounced level falls at edge 2+DB_CYCLES -> o_Cnt updates at edge 3+DB_CYCLES.
  - Glitches shorter than DB_CYCLES are ignored.
- Step rules:
  - Up-press alone: +1. Down-press alone: -1.
  - Both presses in the same cycle: no change, no carry.
  - BCD arithmetic throughout. Digit value 9 +1 -> 0 with carry into the next digit; digit 0 -1 -> 9 with borrow. Each digit always stays within 0..9.
- Limits, with MAX = all digits 9:
  - Wrap mode: MAX+1 -> 0 and 0-1 -> MAX, each with o_Carry=1 for one clock.
  - Saturate mode: MAX+1 -> MAX and 0-1 -> 0, no change, o_Carry=0.
- i_Mode is sampled on the step cycle. Changing it never alters the count by itself.
- Display scan:
  - Free-running divider. o_Digit rotates one-hot 0 -> 1 -> ... -> DIGITS-1 -> 0 every SCAN_DIV clocks.
  - o_FND registered: decodes the enabled digit of the current o_Cnt, updating on the same edge as o_Digit.
  - Encodings 0..9 standard, active-low. Values 10..15 are unreachable; decode them as all segments off (7'h7F).
  - DIGITS=1: o_Digit is constantly 1.
- Reset mid-hold: count returns to 0. The button must be observed released (debounced) before another press registers.

Optional Feature:
- Macro AUTO_REPEAT_EN.
- Defined:
  - While exactly one button's debounced level stays 0, a hold timer runs.
  - At RPT_DELAY clocks after the press pulse, one extra step is issued. A further step follows every RPT_PERIOD clocks.
  - Extra steps obey the same wrap/saturate and carry rules.
  - Timer clears on release, on both buttons down, and on reset.
- Undefined: the RPT_* parameters are ignored; one step per press only; no hold timer is synthesised.

Test Plan (DIGITS=2, DB_CYCLES=4, SCAN_DIV=4, RPT_DELAY=20, RPT_PERIOD=8):
- Reset, then hold i_Push=2'b01 (up pressed) 10 clocks -> o_Cnt=8'h01 at edge 7, o_LED=4'h1. Release, repeat 9 more times -> o_Cnt=8'h10 (BCD carry).
- i_Push[1] low for 3 clocks, then high -> o_Cnt unchanged (glitch rejected).
- Wrap mode, o_Cnt=8'h99, up-press -> o_Cnt=8'h00 and one-clock o_Carry. Down-press from 8'h00 -> 8'h99 and o_Carry.
- Saturate mode at 8'h99, up-press -> stays 8'h99, o_Carry=0. At 8'h00, down-press -> stays 8'h00.
- Both buttons fall in the same clock and are held -> no count change. o_Cnt=8'h42 gives o_Digit alternating 2'b01/2'b10 every 4 clocks, with o_FND 7'b0100100 ("2") and 7'b0011001 ("4") respectively.
- AUTO_REPEAT_EN: hold up 60 clocks from 8'h00 -> 1 press step, then repeat steps at +20, +28, +36 ... -> o_Cnt=8'h06. Assert i_Rst mid-hold -> o_Cnt=8'h00, no steps until release and re-press.
